// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler: latches floor calls into a pending mask, steps the car
// one floor per TRAVEL_TICKS enable ticks and dwells with doors open at each served floor.
module elevator_scheduler #(
    parameter int unsigned TRAVEL_TICKS = 2,
    parameter int unsigned DOOR_TICKS   = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       tick,
    input  logic [7:0] req,
    output logic [7:0] destination,
    output logic [1:0] sim_state,
    output logic [2:0] floor,
    output logic       door_open
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_DOOR = 2'b11
    } state_t;

    localparam logic [3:0] TRAVEL_LAST = 4'(TRAVEL_TICKS - 1);
    localparam logic [3:0] DOOR_LAST   = 4'(DOOR_TICKS - 1);

    state_t     r_state;
    logic [7:0] r_pending;
    logic [2:0] r_floor;
    logic       r_dir;
    logic [3:0] r_cnt;

    function automatic logic [7:0] onehot(input logic [2:0] f);
        return 8'h01 << f;
    endfunction

    function automatic logic [7:0] above_mask(input logic [2:0] f);
        return 8'hFE << f;
    endfunction

    function automatic logic [7:0] below_mask(input logic [2:0] f);
        return ~(8'hFF << f);
    endfunction

    logic [7:0] w_req_eff;
    logic [7:0] w_pending_in;
    logic       w_above;
    logic       w_below;
    logic       w_here;
    logic [2:0] w_step_floor;
    logic       w_step_here;
    logic       w_step_beyond;

    // Calls for the floor whose doors are open are absorbed, not latched.
    always_comb begin
        w_req_eff    = (r_state == ST_DOOR) ? (req & ~onehot(r_floor)) : req;
        w_pending_in = r_pending | w_req_eff;
        w_above      = |(r_pending & above_mask(r_floor));
        w_below      = |(r_pending & below_mask(r_floor));
        w_here       = r_pending[r_floor];
        if (r_state == ST_DOWN) begin
            w_step_floor  = (r_floor == 3'd0) ? 3'd0 : r_floor - 3'd1;
            w_step_beyond = |(r_pending & below_mask(w_step_floor));
        end else begin
            w_step_floor  = (r_floor == 3'd7) ? 3'd7 : r_floor + 3'd1;
            w_step_beyond = |(r_pending & above_mask(w_step_floor));
        end
        w_step_here = r_pending[w_step_floor];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_floor   <= '0;
            r_dir     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            // NOTE: non-blocking updates; a later assignment in a branch overrides this default.
            r_pending <= w_pending_in;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_here) begin
                        r_state   <= ST_DOOR;
                        r_pending <= w_pending_in & ~onehot(r_floor);
                    end else if (w_above && (!w_below || !r_dir)) begin
                        r_state <= ST_UP;
                        r_dir   <= 1'b0;
                    end else if (w_below) begin
                        r_state <= ST_DOWN;
                        r_dir   <= 1'b1;
                    end
                end
                ST_UP, ST_DOWN: begin
                    if (tick) begin
                        if (r_cnt == TRAVEL_LAST) begin
                            r_floor <= w_step_floor;
                            r_cnt   <= '0;
                            if (w_step_here) begin
                                r_state   <= ST_DOOR;
                                r_pending <= w_pending_in & ~onehot(w_step_floor);
                            end else if (!w_step_beyond) begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                ST_DOOR: begin
                    if (req[r_floor]) begin
                        r_cnt <= '0;
                    end else if (tick) begin
                        if (r_cnt == DOOR_LAST) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign destination = r_pending;
    assign sim_state   = r_state;
    assign floor       = r_floor;
    assign door_open   = (r_state == ST_DOOR);

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Single-car elevator scheduler that sits directly upstream of the VGA display controller. Latches floor-call buttons into a pending-request mask, moves the car one floor at a time on a slow enable tick, and holds the doors open at each served floor. Outputs `destination` (pending mask) and `sim_state` (car activity), which feed the display controller's `destination[7:0]` and `sim_state[1:0]` inputs directly.

## Interface
- `TRAVEL_TICKS`, default 2: ticks to move one floor (≥1, counter width 4).
- `DOOR_TICKS`, default 4: ticks doors stay open (≥1, counter width 4).
- `clk`  in  1  system clock (divided clock domain).
- `nrst`  in  1  reset; asynchronous, active-low.
- `tick`  in  1  one-cycle enable pulse from the clock divider; all timing counts these.
- `req`  in  8  floor-call buttons, level, bit i = floor i; OR'd into pending every cycle.
- `destination`  out  8  pending-request mask, bit i = floor i outstanding.
- `sim_state`  out  2  00 idle, 01 moving up, 10 moving down, 11 doors open.
- `floor`  out  3  current car floor, 0..7.
- `door_open`  out  1  high in DOOR state.

## Operation
- States: IDLE (00), UP (01), DOWN (10), DOOR (11); `sim_state` is the state encoding, registered.
- Internal: `pending[7:0]`, `floor[2:0]`, `dir` (0 up, 1 down), `cnt[3:0]`.
- Pending update each cycle: `pending <= (pending | req) & ~clr`. `clr` is one-hot of the floor being served on the DOOR entry cycle. In DOOR, `req[floor]` is masked (not latched) and reloads `cnt` to 0 (door hold).
- above = any pending bit > floor; below = any pending bit < floor; here = `pending[floor]`.
- IDLE:
  - here → DOOR (clear bit).
  - else if above and below → direction per `dir`.
  - else above → UP, `dir`=0; below → DOWN, `dir`=1.
  - else stay.
- UP/DOWN: `cnt` increments on `tick`; on the tick where `cnt == TRAVEL_TICKS-1`, `floor` ±1 and `cnt` <= 0. Arrival check uses the new floor:
  - pending at new floor → DOOR (clear it).
  - else further requests in same direction → stay.
  - else → IDLE.
- DOOR: `cnt` increments on `tick`; when `cnt == DOOR_TICKS-1` on a tick → IDLE. `dir` is retained.
- Saturation: UP never leaves floor 7 and DOWN never leaves floor 0. This holds by construction (no requests beyond the ends); the RTL still clamps.
- `cnt` is cleared on every state change.

## Timing
- Reset (async, `nrst`=0): `pending`=0, `floor`=0, `dir`=0, `cnt`=0, state IDLE. Outputs are `destination`=8'h00, `sim_state`=2'b00, `floor`=0, `door_open`=0.
- `req` asserted in cycle n → `destination` bit set in cycle n+1.
- IDLE decision takes effect in the cycle after `pending` shows the request. The minimum call-to-motion latency is therefore 2 clocks.
- One floor of travel = exactly `TRAVEL_TICKS` tick pulses after entering UP/DOWN. `floor` updates on the clock edge that samples the final tick.
- Door dwell = `DOOR_TICKS` tick pulses after DOOR entry, extended by a reload on each `req[floor]` cycle.
- Simultaneous events:
  - `req` for the floor being cleared on the DOOR entry cycle: clear wins.
  - `req` of another floor in the same cycle: latched.
- `tick` is ignored in IDLE.
- Reset asserted mid-travel or mid-door returns everything to reset values immediately, and all pending calls are lost.
- `tick` high for consecutive cycles counts each cycle.

## Test plan
- Reset: hold `nrst`=0 with `req`=8'hFF → `destination`=00, `sim_state`=00, `floor`=0. Release `nrst` → `destination`=FF one clock later.
- Single call: `req`=8'h08 one cycle, TRAVEL_TICKS=2:
  - `sim_state`=01; `floor` reaches 3 after 6 ticks.
  - Then `sim_state`=11, `destination`=00.
  - After 4 ticks, `sim_state`=00.
- Call at current floor: at floor 0 in IDLE, `req`=8'h01 → DOOR 2 clocks later, `destination` bit 0 never stays set. Holding `req[0]` keeps DOOR indefinitely; release → IDLE after 4 ticks.
- Direction preference: car at floor 3 having moved up, `pending`=8'h81 → serves 7 first (UP), then 0 (DOWN). Check `sim_state` sequence 01,11,00,10,11,00.
- Pass-through service: car moving 0→6, `req`=8'h10 injected while between floors 1 and 2 → doors open at 4 before reaching 6.
- Async reset mid-travel: pulse `nrst` low while `sim_state`=10 → outputs return to reset values without a clock edge.
